// File: rtl/demux_1to4_buf.sv
// 1:4 byte demultiplexer with a small first-word-fall-through FIFO per channel.
// Destination is either the explicit select or an internal round-robin pointer.
module demux_1to4_buf #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               auto_seq,
    input  logic               frame_start,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         seq_ptr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [4][DEPTH];

    logic [PW-1:0] wr_ptr_q [4];
    logic [PW-1:0] wr_ptr_d [4];
    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] rd_ptr_d [4];
    logic [CW-1:0] count_q  [4];
    logic [CW-1:0] count_d  [4];
    logic [1:0]    seq_ptr_q;
    logic [1:0]    seq_ptr_d;

    logic [1:0] dest;
    logic       accept;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        if (!auto_seq) begin
            dest = in_sel;
        end else if (frame_start) begin
            dest = 2'd0;
        end else begin
            dest = seq_ptr_q;
        end
    end

    // Readiness looks only at the current fill level; a same-cycle pop does not help.
    assign in_ready = (count_q[dest] < CW'(DEPTH));
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            push[i]      = accept && (dest == 2'(i));
            out_valid[i] = (count_q[i] != '0);
            pop[i]       = out_valid[i] & out_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (push[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            unique case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_comb begin
        seq_ptr_d = seq_ptr_q;
        if (accept && auto_seq) begin
            seq_ptr_d = dest + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            seq_ptr_q <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            seq_ptr_q <= seq_ptr_d;
        end
    end

    // Storage needs no reset: the slice output is gated by the channel count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr_q[i]] <= in_data;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid[i]) begin
                out_data[i*WIDTH +: WIDTH] = mem[i][rd_ptr_q[i]];
            end
        end
    end

    assign seq_ptr = seq_ptr_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Self-checking bench for demux_1to4_buf: directed vector table, hand-written
// corner sequences, and random traffic against a queue-based reference model.
module tb_demux_1to4_buf;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic               clk;
    logic               reset;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic               in_valid;
    logic               in_ready;
    logic               auto_seq;
    logic               frame_start;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [1:0]         seq_ptr;

    demux_1to4_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .auto_seq   (auto_seq),
        .frame_start(frame_start),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .seq_ptr    (seq_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: one queue per channel plus the round-robin pointer.
    logic [WIDTH-1:0] mq [4][$];
    int               mseq;

    typedef struct {
        logic             v;
        logic [1:0]       sel;
        logic [WIDTH-1:0] d;
        logic [3:0]       ordy;
        logic             exp_ready;
        logic [3:0]       exp_valid;
        logic [31:0]      exp_data;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_dest();
        if (!auto_seq) return int'(in_sel);
        if (frame_start) return 0;
        return mseq;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mseq = 0;
    endtask

    task automatic model_check();
        logic [3:0]  ev;
        logic [31:0] ed;
        int          d;
        ev = '0;
        ed = '0;
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0) begin
                ev[i] = 1'b1;
                ed[i*WIDTH +: WIDTH] = mq[i][0];
            end
        end
        d = model_dest();
        check("model in_ready", {31'd0, in_ready}, {31'd0, mq[d].size() < DEPTH});
        check("model out_valid", {28'd0, out_valid}, {28'd0, ev});
        check("model out_data", out_data, ed);
        check("model seq_ptr", {30'd0, seq_ptr}, 32'(mseq));
    endtask

    task automatic model_update();
        int   d;
        logic acc;
        d   = model_dest();
        acc = in_valid && (mq[d].size() < DEPTH);
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
        end
        if (acc) begin
            mq[d].push_back(in_data);
            if (auto_seq) mseq = (d + 1) % 4;
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                         input logic a, input logic fs, input logic [3:0] ordy);
        in_valid    = v;
        in_sel      = sel;
        in_data     = d;
        auto_seq    = a;
        frame_start = fs;
        out_ready   = ordy;
        #1;
        model_check();
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                       input logic a, input logic fs, input logic [3:0] ordy);
        drive(v, sel, d, a, fs, ordy);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_sel      = 2'd0;
        in_data     = '0;
        auto_seq    = 1'b0;
        frame_start = 1'b0;
        out_ready   = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {28'd0, out_valid}, 32'h0);
        check("reset out_data", out_data, 32'h0);
        check("reset seq_ptr", {30'd0, seq_ptr}, 32'h0);
        check("reset in_ready", {31'd0, in_ready}, 32'h1);
        reset = 1'b0;
        #1;

        // Explicit select, one byte per channel, everything drained immediately.
        tbl[0] = '{1'b1, 2'd0, 8'b10010101, 4'hF, 1'b1, 4'b0000, 32'h0000_0000};
        tbl[1] = '{1'b1, 2'd1, 8'b01000011, 4'hF, 1'b1, 4'b0001, 32'h0000_0095};
        tbl[2] = '{1'b1, 2'd2, 8'b10111111, 4'hF, 1'b1, 4'b0010, 32'h0000_4300};
        tbl[3] = '{1'b1, 2'd3, 8'b01000101, 4'hF, 1'b1, 4'b0100, 32'h00BF_0000};
        tbl[4] = '{1'b0, 2'd0, 8'h00,       4'hF, 1'b1, 4'b1000, 32'h4500_0000};
        tbl[5] = '{1'b0, 2'd0, 8'h00,       4'hF, 1'b1, 4'b0000, 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, 1'b0, 1'b0, tbl[i].ordy);
            check("tbl in_ready", {31'd0, in_ready}, {31'd0, tbl[i].exp_ready});
            check("tbl out_valid", {28'd0, out_valid}, {28'd0, tbl[i].exp_valid});
            check("tbl out_data", out_data, tbl[i].exp_data);
            step();
        end

        // Channel full: ch2 blocked, fifth byte held until a slot frees.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 8'(8'h10 + i), 1'b0, 1'b0, 4'b1011);
            check("full accept", {31'd0, in_ready}, 32'h1);
            step();
        end
        repeat (2) begin
            drive(1'b1, 2'd2, 8'h14, 1'b0, 1'b0, 4'b1011);
            check("full stall", {31'd0, in_ready}, 32'h0);
            step();
        end
        drive(1'b1, 2'd2, 8'h14, 1'b0, 1'b0, 4'b1111);
        check("full no same-cycle pop", {31'd0, in_ready}, 32'h0);
        check("full head 10", out_data, 32'h0010_0000);
        step();
        drive(1'b1, 2'd2, 8'h14, 1'b0, 1'b0, 4'b1111);
        check("full accept after pop", {31'd0, in_ready}, 32'h1);
        check("full head 11", out_data, 32'h0011_0000);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b1111);
            check("full drain order", out_data, {8'h00, 8'(8'h12 + i), 16'h0000});
            step();
        end
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b1111);

        // Round-robin from seq_ptr 0 with consumers stalled.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'd0, 8'(8'hA0 + i), 1'b1, 1'b0, 4'b0000);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 4'b1111);
        check("rr seq_ptr", {30'd0, seq_ptr}, 32'd2);
        check("rr heads", out_data, 32'hA3A2_A1A0);
        check("rr valid", {28'd0, out_valid}, 32'hF);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 4'b1111);
        check("rr wrap heads", out_data, 32'h0000_A5A4);
        step();

        // frame_start forces channel 0 and resyncs the pointer.
        cyc(1'b1, 2'd3, 8'h55, 1'b1, 1'b1, 4'b0000);
        cyc(1'b1, 2'd3, 8'h66, 1'b1, 1'b0, 4'b0000);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 4'b0000);
        check("fs heads", out_data, 32'h0000_6655);
        check("fs seq_ptr", {30'd0, seq_ptr}, 32'd2);
        step();

        // Stall in auto mode: ch1 full, pointer must hold.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 8'(8'hB0 + i), 1'b0, 1'b0, 4'b0000);
        cyc(1'b1, 2'd0, 8'hC0, 1'b1, 1'b1, 4'b0000);
        repeat (3) begin
            drive(1'b1, 2'd0, 8'hC1, 1'b1, 1'b0, 4'b0000);
            check("stall in_ready", {31'd0, in_ready}, 32'h0);
            check("stall seq_ptr", {30'd0, seq_ptr}, 32'd1);
            check("stall valid", {28'd0, out_valid}, 32'h3);
            step();
        end
        cyc(1'b1, 2'd0, 8'hC1, 1'b1, 1'b0, 4'b0010);
        drive(1'b1, 2'd0, 8'hC1, 1'b1, 1'b0, 4'b0000);
        check("stall release", {31'd0, in_ready}, 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 4'b0000);
        check("stall seq after", {30'd0, seq_ptr}, 32'd2);
        step();

        // Async reset between edges with data buffered.
        cyc(1'b1, 2'd2, 8'h77, 1'b0, 1'b0, 4'b0000);
        reset = 1'b1;
        #2;
        check("async out_valid", {28'd0, out_valid}, 32'h0);
        check("async out_data", out_data, 32'h0);
        check("async seq_ptr", {30'd0, seq_ptr}, 32'h0);
        check("async in_ready", {31'd0, in_ready}, 32'h1);
        reset = 1'b0;
        model_reset();
        #1;
        cyc(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b1111);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 4'b1111);
        check("async no stale", {28'd0, out_valid}, 32'h0);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom_range(0, 7) == 0), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
